// File: rtl/vga_timing_tracker.sv
// VGA timing sink: recovers x/y from h_sync/v_sync/DE,
// measures line/frame periods and locks onto the expected mode.
module vga_timing_tracker #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic        de_in,
  output logic        pixel_valid,
  output logic [9:0]  x_pixel,
  output logic [9:0]  y_pixel,
  output logic        frame_start,
  output logic [10:0] h_period,
  output logic [9:0]  v_period,
  output logic        locked,
  output logic        timing_err
);

  localparam logic [10:0] HT = 11'(H_TOTAL);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] WD = 11'(2 * H_TOTAL);
  localparam logic [9:0]  VT = 10'(V_TOTAL);
  localparam logic [9:0]  VA = 10'(V_ACTIVE);
  localparam logic [7:0]  LF = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  state_t state;

  logic hs1, vs1, de1;
  logic hs2, vs2, de2;
  logic h_fall, v_fall, de_fall;

  logic [10:0] h_cnt, h_cnt_inc;
  logic [10:0] de_w, de_w_inc;
  logic [9:0]  v_cnt, v_cnt_inc;
  logic [9:0]  act, act_inc;
  logic [9:0]  x_nxt, y_nxt;
  logic [7:0]  match_cnt, mc_inc;
  logic        line_ok, line_ok_cur;
  logic        match, wd_trip;

  assign h_fall  = hs2 & ~hs1;
  assign v_fall  = vs2 & ~vs1;
  assign de_fall = de2 & ~de1;

  always_comb begin
    x_nxt = '0;
    if (de1 && de2)
      x_nxt = (&x_pixel) ? x_pixel : x_pixel + 10'd1;
    y_nxt = y_pixel;
    unique case (1'b1)
      v_fall:  y_nxt = '0;
      de_fall: y_nxt = (&y_pixel) ? y_pixel
                                  : y_pixel + 10'd1;
      default: y_nxt = y_pixel;
    endcase
    h_cnt_inc = (&h_cnt) ? h_cnt : h_cnt + 11'd1;
    de_w_inc  = (&de_w) ? de_w : de_w + 11'd1;
    v_cnt_inc = v_cnt;
    if (h_fall && !(&v_cnt))
      v_cnt_inc = v_cnt + 10'd1;
    act_inc = act;
    if (de_fall && !(&act))
      act_inc = act + 10'd1;
    // the line ending this cycle still belongs to the old frame
    line_ok_cur = line_ok;
    if (de_fall && de_w != HA)
      line_ok_cur = 1'b0;
    if (h_fall && h_cnt != HT)
      line_ok_cur = 1'b0;
    match = line_ok_cur && (v_cnt_inc == VT)
         && (act_inc == VA);
    wd_trip = !h_fall && (h_cnt == WD);
    mc_inc = match_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      de1         <= 1'b0;
      hs2         <= 1'b0;
      vs2         <= 1'b0;
      de2         <= 1'b0;
      pixel_valid <= 1'b0;
      x_pixel     <= '0;
      y_pixel     <= '0;
      frame_start <= 1'b0;
      h_cnt       <= '0;
      h_period    <= '0;
      v_cnt       <= '0;
      v_period    <= '0;
      de_w        <= '0;
      act         <= '0;
      line_ok     <= 1'b0;
    end else begin
      hs1 <= h_sync_in;
      vs1 <= v_sync_in;
      de1 <= de_in;
      hs2 <= hs1;
      vs2 <= vs1;
      de2 <= de1;
      pixel_valid <= de1;
      x_pixel     <= x_nxt;
      y_pixel     <= y_nxt;
      frame_start <= de1 && (x_nxt == '0)
                  && (y_nxt == '0);
      if (h_fall) begin
        h_cnt    <= 11'd1;
        h_period <= h_cnt;
      end else begin
        h_cnt <= h_cnt_inc;
      end
      if (de1)
        de_w <= de2 ? de_w_inc : 11'd1;
      else
        de_w <= '0;
      if (v_fall) begin
        v_period <= v_cnt_inc;
        v_cnt    <= '0;
        act      <= '0;
        line_ok  <= 1'b1;
      end else begin
        v_cnt   <= v_cnt_inc;
        act     <= act_inc;
        line_ok <= line_ok_cur;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      match_cnt  <= '0;
      locked     <= 1'b0;
      timing_err <= 1'b0;
    end else begin
      timing_err <= 1'b0;
      if (wd_trip) begin
        timing_err <= (state == LOCKED);
        state      <= SEARCH;
        locked     <= 1'b0;
        match_cnt  <= '0;
      end else if (v_fall) begin
        unique case (state)
          SEARCH: begin
            state     <= VERIFY;
            match_cnt <= '0;
          end
          VERIFY: begin
            if (!match) begin
              match_cnt <= '0;
            end else if (mc_inc >= LF) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
            end else begin
              match_cnt <= mc_inc;
            end
          end
          LOCKED: begin
            if (!match) begin
              timing_err <= 1'b1;
              locked     <= 1'b0;
              state      <= SEARCH;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule
